// File: rtl/e203_lsu_nsplit.sv
// e203_lsu_nsplit: routes one ICB load/store stream to N_PORT ports by address, in-order rsp, local misalign errors; ports i_cmd_*/i_rsp_* upstream, o_cmd_*/o_rsp_* per port, lsu_active clock-gate enable
module e203_lsu_nsplit #(
  parameter int N_PORT = 3,
  parameter int AW = 32,
  parameter int TAGW = 1,
  parameter int OUTS_DEPTH = 2,
  parameter logic [(N_PORT-1)*AW-1:0] RGN_BASE = {32'h9000_0000, 32'h8000_0000},
  parameter logic [(N_PORT-1)*AW-1:0] RGN_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_valid,
  output logic                 i_cmd_ready,
  input  logic [AW-1:0]        i_cmd_addr,
  input  logic                 i_cmd_read,
  input  logic [31:0]          i_cmd_wdata,
  input  logic [3:0]           i_cmd_wmask,
  input  logic [1:0]           i_cmd_size,
  input  logic                 i_cmd_usign,
  input  logic [TAGW-1:0]      i_cmd_itag,
  output logic                 i_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [31:0]          i_rsp_rdata,
  output logic                 i_rsp_err,
  output logic                 i_rsp_misalgn,
  output logic [TAGW-1:0]      i_rsp_itag,
  output logic                 lsu_active,
  output logic [N_PORT-1:0]    o_cmd_valid,
  input  logic [N_PORT-1:0]    o_cmd_ready,
  output logic [AW-1:0]        o_cmd_addr,
  output logic                 o_cmd_read,
  output logic [31:0]          o_cmd_wdata,
  output logic [3:0]           o_cmd_wmask,
  output logic [1:0]           o_cmd_size,
  input  logic [N_PORT-1:0]    o_rsp_valid,
  output logic [N_PORT-1:0]    o_rsp_ready,
  input  logic [N_PORT-1:0]    o_rsp_err,
  input  logic [N_PORT*32-1:0] o_rsp_rdata
);
  localparam int PW = N_PORT > 1 ? $clog2(N_PORT) : 1;
  localparam int DW = OUTS_DEPTH > 1 ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);
  typedef struct packed {
    logic [PW-1:0]   port;
    logic            lerr;
    logic            read;
    logic [1:0]      size;
    logic            usign;
    logic [1:0]      a;
    logic [TAGW-1:0] itag;
  } ent_t;
  ent_t mem [OUTS_DEPTH];
  ent_t h;
  logic [DW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [PW-1:0] sel;
  logic mis, full, empty, push, pop;
  logic [31:0] rd, d, ext;
  always_comb begin
    sel = PW'(N_PORT - 1);
    for (int k = N_PORT - 2; k >= 0; k--)
      if ((i_cmd_addr & RGN_MASK[k*AW +: AW]) == RGN_BASE[k*AW +: AW]) sel = PW'(k);
  end
  assign mis = (i_cmd_size == 2'd3) | ((i_cmd_size == 2'd1) & i_cmd_addr[0]) |
               ((i_cmd_size == 2'd2) & (i_cmd_addr[1:0] != 2'd0));
  assign full = cnt == CW'(OUTS_DEPTH);
  assign empty = cnt == '0;
  assign o_cmd_valid = (i_cmd_valid & ~full & ~mis) ? (N_PORT'(1) << sel) : '0;
  assign i_cmd_ready = ~full & (mis | o_cmd_ready[sel]);
  assign o_cmd_addr = i_cmd_addr;
  assign o_cmd_read = i_cmd_read;
  assign o_cmd_wdata = i_cmd_wdata;
  assign o_cmd_wmask = i_cmd_wmask;
  assign o_cmd_size = i_cmd_size;
  assign push = i_cmd_valid & i_cmd_ready;
  assign h = mem[rp];
  assign i_rsp_valid = ~empty & (h.lerr | o_rsp_valid[h.port]);
  assign o_rsp_ready = (~empty & ~h.lerr) ? (N_PORT'(i_rsp_ready) << h.port) : '0;
  assign pop = i_rsp_valid & i_rsp_ready;
  assign rd = o_rsp_rdata[32*h.port +: 32];
  assign d = rd >> {h.a, 3'b000};
  always_comb
    ext = h.size == 2'd0 ? {{24{~h.usign & d[7]}}, d[7:0]} :
          h.size == 2'd1 ? {{16{~h.usign & d[15]}}, d[15:0]} : d;
  assign i_rsp_err = h.lerr | o_rsp_err[h.port];
  assign i_rsp_misalgn = h.lerr;
  assign i_rsp_rdata = (i_rsp_err | ~h.read) ? 32'd0 : ext;
  assign i_rsp_itag = h.itag;
  assign lsu_active = i_cmd_valid | ~empty;
  always_ff @(posedge clk)
    if (push) mem[wp] <= '{sel, mis, i_cmd_read, i_cmd_size, i_cmd_usign, i_cmd_addr[1:0], i_cmd_itag};
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp == DW'(OUTS_DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == DW'(OUTS_DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_e203_lsu_nsplit.sv
// tb_e203_lsu_nsplit: directed self-checking bench for e203_lsu_nsplit
module tb_e203_lsu_nsplit;
  logic clk = 0, rst;
  logic i_cmd_valid, i_cmd_ready, i_cmd_read, i_cmd_usign;
  logic [31:0] i_cmd_addr, i_cmd_wdata, o_cmd_addr, o_cmd_wdata, i_rsp_rdata;
  logic [3:0] i_cmd_wmask, o_cmd_wmask;
  logic [1:0] i_cmd_size, o_cmd_size;
  logic [0:0] i_cmd_itag, i_rsp_itag;
  logic i_rsp_valid, i_rsp_ready, i_rsp_err, i_rsp_misalgn, lsu_active, o_cmd_read;
  logic [2:0] o_cmd_valid, o_cmd_ready, o_rsp_valid, o_rsp_ready, o_rsp_err;
  logic [95:0] o_rsp_rdata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  e203_lsu_nsplit dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_read(i_cmd_read), .i_cmd_wdata(i_cmd_wdata),
    .i_cmd_wmask(i_cmd_wmask), .i_cmd_size(i_cmd_size), .i_cmd_usign(i_cmd_usign),
    .i_cmd_itag(i_cmd_itag), .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err), .i_rsp_misalgn(i_rsp_misalgn),
    .i_rsp_itag(i_rsp_itag), .lsu_active(lsu_active), .o_cmd_valid(o_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .o_cmd_addr(o_cmd_addr), .o_cmd_read(o_cmd_read),
    .o_cmd_wdata(o_cmd_wdata), .o_cmd_wmask(o_cmd_wmask), .o_cmd_size(o_cmd_size),
    .o_rsp_valid(o_rsp_valid), .o_rsp_ready(o_rsp_ready), .o_rsp_err(o_rsp_err),
    .o_rsp_rdata(o_rsp_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic [31:0] a, input logic r, input logic [1:0] s, input logic u, input logic t);
    i_cmd_valid = 1;
    i_cmd_addr = a;
    i_cmd_read = r;
    i_cmd_size = s;
    i_cmd_usign = u;
    i_cmd_itag = t;
    #1;
  endtask
  initial begin
    rst = 1;
    i_cmd_valid = 0; i_cmd_addr = 0; i_cmd_read = 0; i_cmd_wdata = 32'h1234_5678;
    i_cmd_wmask = 4'hF; i_cmd_size = 0; i_cmd_usign = 0; i_cmd_itag = 0;
    i_rsp_ready = 1; o_cmd_ready = 3'b111; o_rsp_valid = 0; o_rsp_err = 0; o_rsp_rdata = 0;
    cyc; cyc;
    rst = 0;
    #1;
    chk("rst_rsp_valid", i_rsp_valid, 0);
    chk("rst_rsp_ready", o_rsp_ready, 0);
    chk("rst_active", lsu_active, 0);
    chk("rst_cmd_ready", i_cmd_ready, 1);
    cmd(32'h8000_0010, 1, 2, 0, 1);
    chk("lw_ovalid", o_cmd_valid, 3'b001);
    chk("lw_oaddr", o_cmd_addr, 32'h8000_0010);
    chk("lw_wdata", o_cmd_wdata, 32'h1234_5678);
    cyc;
    i_cmd_valid = 0;
    #1;
    chk("lw_wait_rsp", i_rsp_valid, 0);
    chk("lw_active", lsu_active, 1);
    o_rsp_valid = 3'b001; o_rsp_rdata[31:0] = 32'hDEAD_BEEF;
    #1;
    chk("lw_rsp_valid", i_rsp_valid, 1);
    chk("lw_rdata", i_rsp_rdata, 32'hDEAD_BEEF);
    chk("lw_err", i_rsp_err, 0);
    chk("lw_itag", i_rsp_itag, 1);
    chk("lw_oready", o_rsp_ready, 3'b001);
    cyc;
    o_rsp_valid = 0;
    #1;
    chk("lw_idle", lsu_active, 0);
    cmd(32'h9000_0003, 1, 0, 0, 0);
    chk("lb_ovalid", o_cmd_valid, 3'b010);
    cyc;
    i_cmd_valid = 0; o_rsp_valid = 3'b010; o_rsp_rdata[63:32] = 32'h8000_0000;
    #1;
    chk("lb_rdata", i_rsp_rdata, 32'hFFFF_FF80);
    chk("lb_oready", o_rsp_ready, 3'b010);
    cyc;
    o_rsp_valid = 0;
    cmd(32'h9000_0003, 1, 0, 1, 0);
    cyc;
    i_cmd_valid = 0; o_rsp_valid = 3'b010;
    #1;
    chk("lbu_rdata", i_rsp_rdata, 32'h0000_0080);
    cyc;
    o_rsp_valid = 0;
    cmd(32'h8000_0002, 1, 1, 0, 1);
    chk("lh_ovalid", o_cmd_valid, 3'b001);
    cyc;
    i_cmd_valid = 0; o_rsp_valid = 3'b001; o_rsp_rdata[31:0] = 32'h8001_1234;
    #1;
    chk("lh_rdata", i_rsp_rdata, 32'hFFFF_8001);
    cyc;
    o_rsp_valid = 0;
    o_cmd_ready = 3'b000;
    cmd(32'h1000_0002, 0, 2, 0, 1);
    chk("sw_mis_ovalid", o_cmd_valid, 3'b000);
    chk("sw_mis_ready", i_cmd_ready, 1);
    chk("sw_mis_same_cyc", i_rsp_valid, 0);
    cyc;
    i_cmd_valid = 0; o_cmd_ready = 3'b111;
    #1;
    chk("mis_rsp_valid", i_rsp_valid, 1);
    chk("mis_err", i_rsp_err, 1);
    chk("mis_misalgn", i_rsp_misalgn, 1);
    chk("mis_rdata", i_rsp_rdata, 0);
    chk("mis_itag", i_rsp_itag, 1);
    chk("mis_oready", o_rsp_ready, 0);
    cyc;
    cmd(32'h8000_0001, 1, 1, 0, 0);
    chk("lh_mis_ovalid", o_cmd_valid, 3'b000);
    cyc;
    i_cmd_valid = 0;
    #1;
    chk("lh_mis_misalgn", i_rsp_misalgn, 1);
    cyc;
    cmd(32'h2000_0000, 0, 2, 0, 0);
    chk("sw_biu_ovalid", o_cmd_valid, 3'b100);
    chk("sw_biu_read", o_cmd_read, 0);
    cyc;
    i_cmd_valid = 0; o_rsp_valid = 3'b100; o_rsp_err = 3'b100; o_rsp_rdata[95:64] = 32'hCAFE_F00D;
    #1;
    chk("sw_bus_err", i_rsp_err, 1);
    chk("sw_bus_misalgn", i_rsp_misalgn, 0);
    chk("sw_bus_rdata", i_rsp_rdata, 0);
    cyc;
    o_rsp_valid = 0; o_rsp_err = 0;
    i_rsp_ready = 1;
    cmd(32'h2000_0000, 1, 2, 0, 0);
    cyc;
    cmd(32'h8000_0000, 1, 2, 0, 1);
    chk("ord_p0_ovalid", o_cmd_valid, 3'b001);
    cyc;
    o_rsp_valid = 3'b001; o_rsp_rdata[31:0] = 32'h1111_1111;
    cmd(32'h9000_0000, 1, 2, 0, 0);
    chk("full_cmd_ready", i_cmd_ready, 0);
    chk("full_ovalid", o_cmd_valid, 3'b000);
    chk("ord_held_valid", i_rsp_valid, 0);
    chk("ord_held_ready", o_rsp_ready, 3'b100);
    cyc;
    chk("ord_still_held", i_rsp_valid, 0);
    o_rsp_valid = 3'b101; o_rsp_rdata[95:64] = 32'h2222_2222;
    #1;
    chk("ord_head_rdata", i_rsp_rdata, 32'h2222_2222);
    chk("ord_head_itag", i_rsp_itag, 0);
    chk("full_pop_no_bypass", i_cmd_ready, 0);
    cyc;
    o_rsp_valid = 3'b001;
    #1;
    chk("ord_second_itag", i_rsp_itag, 1);
    chk("ord_second_rdata", i_rsp_rdata, 32'h1111_1111);
    chk("ord_second_oready", o_rsp_ready, 3'b001);
    chk("third_cmd_ready", i_cmd_ready, 1);
    chk("third_ovalid", o_cmd_valid, 3'b010);
    cyc;
    i_cmd_valid = 0; o_rsp_valid = 0;
    #1;
    chk("wrap_head_wait", i_rsp_valid, 0);
    chk("wrap_active", lsu_active, 1);
    o_rsp_valid = 3'b010; o_rsp_rdata[63:32] = 32'h3333_3333;
    #1;
    chk("wrap_rdata", i_rsp_rdata, 32'h3333_3333);
    chk("wrap_oready", o_rsp_ready, 3'b010);
    cyc;
    o_rsp_valid = 0;
    #1;
    chk("wrap_idle", lsu_active, 0);
    i_rsp_ready = 0;
    cmd(32'h2000_0000, 1, 2, 0, 0);
    cyc;
    cmd(32'h2000_0004, 1, 2, 0, 1);
    cyc;
    i_cmd_valid = 0;
    #1;
    chk("pre_rst_full", i_cmd_ready, 0);
    rst = 1;
    cyc;
    i_rsp_ready = 1; o_rsp_valid = 3'b100;
    #1;
    chk("mid_rst_rsp_valid", i_rsp_valid, 0);
    chk("mid_rst_active", lsu_active, 0);
    chk("mid_rst_oready", o_rsp_ready, 0);
    rst = 0;
    cyc;
    chk("post_rst_rsp_valid", i_rsp_valid, 0);
    chk("post_rst_oready", o_rsp_ready, 0);
    chk("post_rst_cmd_ready", i_cmd_ready, 1);
    o_rsp_valid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
